// File: rtl/calc_core_param.sv
// ---------------------------------------------------------------------------
// calc_core_param
//   Two-operand decimal add/subtract calculator core driven by a keyboard
//   scanner. Key presses are sampled on a slow divider tick. Each accepted
//   key takes effect when the key is released.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 4)
//   MAX_DIGITS maximum decimal digits accepted per operand
//   DIV_LOG2   key-sample tick period is 2^DIV_LOG2 clk_in cycles (0 = every cycle)
//
// Ports
//   clk_in    in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   key_flag  in   key currently held
//   key_code  in   [4:0] scanner code of the held key
//   display   out  [WIDTH-1:0] operand being entered, or result in EQUAL
//   state_o   out  [1:0] 0=FIRST_NUM, 1=SECOND_NUM, 2=EQUAL
//   op_o      out  pending operator, 0=add 1=subtract
//   ovf       out  last result wrapped (carry on add, borrow on subtract)
//   key_ack   out  one-cycle pulse after an accepted key release
// ---------------------------------------------------------------------------
module calc_core_param #(
  parameter int WIDTH      = 10,
  parameter int MAX_DIGITS = 3,
  parameter int DIV_LOG2   = 10
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             key_flag,
  input  logic [4:0]       key_code,
  output logic [WIDTH-1:0] display,
  output logic [1:0]       state_o,
  output logic             op_o,
  output logic             ovf,
  output logic             key_ack
);

  localparam int CNT_W = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  // Encoding 3 is unused; the FSM recovers from it to FIRST_NUM.
  typedef enum logic [1:0] {
    FIRST_NUM  = 2'd0,
    SECOND_NUM = 2'd1,
    EQUAL      = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_DIGIT,
    K_ADD,
    K_SUB,
    K_EQ,
    K_CLR
  } key_t;

  // -------------------------------------------------------------------------
  // Key-sample tick
  // -------------------------------------------------------------------------
  logic tick;

  if (DIV_LOG2 == 0) begin : g_no_div
    assign tick = 1'b1;
  end else begin : g_div
    logic [DIV_LOG2-1:0] div_cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) div_cnt <= '0;
      else        div_cnt <= div_cnt + DIV_LOG2'(1);
    end

    assign tick = (div_cnt == '0);
  end

  // -------------------------------------------------------------------------
  // Release detection: key_flag only matters on ticks, so bounce between
  // ticks is invisible and a long hold yields a single event on release.
  // -------------------------------------------------------------------------
  logic prev_flag;
  logic release_evt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)    prev_flag <= 1'b0;
    else if (tick) prev_flag <= key_flag;
  end

  assign release_evt = tick && prev_flag && !key_flag;

  // -------------------------------------------------------------------------
  // Key decode
  // -------------------------------------------------------------------------
  key_t       key_kind;
  logic [3:0] key_digit;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    key_kind  = K_NONE;
    key_digit = 4'd0;
    case (key_code)
      5'd0, 5'd1, 5'd2: begin
        key_kind  = K_DIGIT;
        key_digit = 4'(key_code + 5'd1);
      end
      5'd4, 5'd5, 5'd6: begin
        key_kind  = K_DIGIT;
        key_digit = key_code[3:0];
      end
      5'd8, 5'd9, 5'd10: begin
        key_kind  = K_DIGIT;
        key_digit = 4'(key_code - 5'd1);
      end
      5'd13:   key_kind = K_DIGIT;
      5'd3:    key_kind = K_ADD;
      5'd11:   key_kind = K_SUB;
      5'd7:    key_kind = K_EQ;
      5'd12:   key_kind = K_CLR;
      default: key_kind = K_NONE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Calculator state
  // -------------------------------------------------------------------------
  state_t           state_q, state_n;
  logic [WIDTH-1:0] acc_q, acc_n;     // operand being entered
  logic [WIDTH-1:0] a_q, a_n;         // latched first operand
  logic [WIDTH-1:0] res_q, res_n;     // last result, reused when chaining
  logic [CNT_W-1:0] cnt_q, cnt_n;     // digits entered in current operand
  logic             op_n, ovf_n, ack_n;
  logic [WIDTH-1:0] display_n;
  logic [WIDTH:0]   calc_ext;         // extra MSB is carry/borrow

  always_comb begin
    state_n   = state_q;
    acc_n     = acc_q;
    a_n       = a_q;
    res_n     = res_q;
    cnt_n     = cnt_q;
    op_n      = op_o;
    ovf_n     = ovf;
    ack_n     = 1'b0;
    calc_ext  = op_o ? ({1'b0, a_q} - {1'b0, acc_q})
                     : ({1'b0, a_q} + {1'b0, acc_q});

    case (state_q)
      FIRST_NUM, SECOND_NUM, EQUAL: begin
        if (release_evt) begin
          case (key_kind)
            K_CLR: begin
              acc_n   = '0;
              a_n     = '0;
              res_n   = '0;
              cnt_n   = '0;
              op_n    = 1'b0;
              ovf_n   = 1'b0;
              state_n = FIRST_NUM;
              ack_n   = 1'b1;
            end
            K_DIGIT: begin
              ack_n = 1'b1;
              if (state_q == EQUAL) begin
                // A digit after a result starts a fresh calculation.
                acc_n   = WIDTH'(key_digit);
                cnt_n   = CNT_W'(1);
                ovf_n   = 1'b0;
                state_n = FIRST_NUM;
              end else if (cnt_q < CNT_MAX) begin
                acc_n = acc_q * WIDTH'(10) + WIDTH'(key_digit);
                cnt_n = cnt_q + CNT_W'(1);
              end
            end
            K_ADD, K_SUB: begin
              ack_n = 1'b1;
              op_n  = (key_kind == K_SUB);
              // In SECOND_NUM an operator key only changes the pending op.
              if (state_q != SECOND_NUM) begin
                a_n     = (state_q == EQUAL) ? res_q : acc_q;
                acc_n   = '0;
                cnt_n   = '0;
                state_n = SECOND_NUM;
              end
            end
            K_EQ: begin
              if (state_q == SECOND_NUM) begin
                ack_n   = 1'b1;
                res_n   = calc_ext[WIDTH-1:0];
                ovf_n   = calc_ext[WIDTH];
                state_n = EQUAL;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        acc_n   = '0;
        a_n     = '0;
        res_n   = '0;
        cnt_n   = '0;
        op_n    = 1'b0;
        ovf_n   = 1'b0;
        state_n = FIRST_NUM;
      end
    endcase

    display_n = (state_n == EQUAL) ? res_n : acc_n;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIRST_NUM;
      acc_q   <= '0;
      a_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_o    <= 1'b0;
      ovf     <= 1'b0;
      key_ack <= 1'b0;
      display <= '0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      a_q     <= a_n;
      res_q   <= res_n;
      cnt_q   <= cnt_n;
      op_o    <= op_n;
      ovf     <= ovf_n;
      key_ack <= ack_n;
      display <= display_n;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_calc_core_param.sv
module tb_calc_core_param;

  localparam int W    = 10;
  localparam int MAXD = 3;
  localparam int MOD  = 1 << W;

  logic         clk_in = 1'b0;
  logic         rst_n  = 1'b1;

  // Instance with a tick every cycle
  logic         key_flag0 = 1'b0;
  logic [4:0]   key_code0 = 5'd0;
  logic [W-1:0] display0;
  logic [1:0]   state0;
  logic         op0, ovf0, key_ack0;

  // Instance with a tick every 8 cycles
  logic         key_flag3 = 1'b0;
  logic [4:0]   key_code3 = 5'd0;
  logic [W-1:0] display3;
  logic [1:0]   state3;
  logic         op3, ovf3, key_ack3;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  calc_core_param #(.WIDTH(W), .MAX_DIGITS(MAXD), .DIV_LOG2(0)) dut0 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .key_flag (key_flag0),
    .key_code (key_code0),
    .display  (display0),
    .state_o  (state0),
    .op_o     (op0),
    .ovf      (ovf0),
    .key_ack  (key_ack0)
  );

  calc_core_param #(.WIDTH(W), .MAX_DIGITS(MAXD), .DIV_LOG2(3)) dut3 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .key_flag (key_flag3),
    .key_code (key_code3),
    .display  (display3),
    .state_o  (state3),
    .op_o     (op3),
    .ovf      (ovf3),
    .key_ack  (key_ack3)
  );

  // -------------------------------------------------------------------------
  // Reference model: calculator behaviour in plain integer arithmetic.
  // -------------------------------------------------------------------------
  int m_st, m_a, m_acc, m_cnt, m_res, m_op, m_ovf;

  task automatic model_reset();
    m_st = 0; m_a = 0; m_acc = 0; m_cnt = 0; m_res = 0; m_op = 0; m_ovf = 0;
  endtask

  function automatic int digit_of(input int code);
    if (code >= 0 && code <= 2)  return code + 1;
    if (code >= 4 && code <= 6)  return code;
    if (code >= 8 && code <= 10) return code - 1;
    if (code == 13)              return 0;
    return -1;
  endfunction

  task automatic model_apply(input int code, output int ack);
    int d;
    int raw;
    ack = 0;
    d   = digit_of(code);
    if (code == 12) begin
      model_reset();
      ack = 1;
    end else if (d >= 0) begin
      ack = 1;
      if (m_st == 2) begin
        m_acc = d; m_cnt = 1; m_ovf = 0; m_st = 0;
      end else if (m_cnt < MAXD) begin
        m_acc = (m_acc * 10 + d) % MOD;
        m_cnt++;
      end
    end else if (code == 3 || code == 11) begin
      ack  = 1;
      m_op = (code == 11) ? 1 : 0;
      if (m_st == 0) begin
        m_a = m_acc; m_acc = 0; m_cnt = 0; m_st = 1;
      end else if (m_st == 2) begin
        m_a = m_res; m_acc = 0; m_cnt = 0; m_st = 1;
      end
    end else if (code == 7 && m_st == 1) begin
      ack = 1;
      if (m_op == 1) begin
        raw   = m_a - m_acc;
        m_ovf = (raw < 0) ? 1 : 0;
        m_res = (raw + MOD) % MOD;
      end else begin
        raw   = m_a + m_acc;
        m_ovf = (raw >= MOD) ? 1 : 0;
        m_res = raw % MOD;
      end
      m_st = 2;
    end
  endtask

  // Press and release one key on dut0 and compare against the model.
  task automatic press0(input int code, input int hold, input string tag);
    int           acks;
    int           exp_ack;
    int           m_disp;
    logic [W-1:0] exp_disp;
    model_apply(code, exp_ack);
    m_disp   = (m_st == 2) ? m_res : m_acc;
    exp_disp = m_disp[W-1:0];
    acks      = 0;
    key_code0 = 5'(code);
    key_flag0 = 1'b1;
    repeat (hold) begin
      @(posedge clk_in); #1;
      if (key_ack0) acks++;
    end
    key_flag0 = 1'b0;
    repeat (4) begin
      @(posedge clk_in); #1;
      if (key_ack0) acks++;
    end
    total++;
    if (acks != exp_ack) begin
      bad++;
      $display("FAIL %s key_ack count got=%0d exp=%0d", tag, acks, exp_ack);
    end
    total++;
    if (display0 !== exp_disp) begin
      bad++;
      $display("FAIL %s display got=%0d exp=%0d", tag, display0, exp_disp);
    end
    total++;
    if (state0 !== 2'(m_st)) begin
      bad++;
      $display("FAIL %s state got=%0d exp=%0d", tag, state0, m_st);
    end
    total++;
    if (op0 !== 1'(m_op)) begin
      bad++;
      $display("FAIL %s op got=%0b exp=%0d", tag, op0, m_op);
    end
    total++;
    if (ovf0 !== 1'(m_ovf)) begin
      bad++;
      $display("FAIL %s ovf got=%0b exp=%0d", tag, ovf0, m_ovf);
    end
  endtask

  task automatic expect_final(input string tag, input int disp, input int st, input int ov);
    logic [W-1:0] d;
    d = disp[W-1:0];
    total++;
    if (display0 !== d) begin
      bad++;
      $display("FAIL %s final display got=%0d exp=%0d", tag, display0, disp);
    end
    total++;
    if (state0 !== 2'(st)) begin
      bad++;
      $display("FAIL %s final state got=%0d exp=%0d", tag, state0, st);
    end
    total++;
    if (ovf0 !== 1'(ov)) begin
      bad++;
      $display("FAIL %s final ovf got=%0b exp=%0d", tag, ovf0, ov);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({display0, state0, op0, ovf0, key_ack0} !== '0) begin
      bad++;
      $display("FAIL reset dut0 outputs got=%h exp=0", {display0, state0, op0, ovf0, key_ack0});
    end
    total++;
    if ({display3, state3, op3, ovf3, key_ack3} !== '0) begin
      bad++;
      $display("FAIL reset dut3 outputs got=%h exp=0", {display3, state3, op3, ovf3, key_ack3});
    end
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add();
    int seq[7] = '{12, 0, 1, 3, 2, 4, 7};
    foreach (seq[i]) press0(seq[i], 1 + (i % 3), $sformatf("add[%0d]", i));
    expect_final("add", 46, 2, 0);
  endtask

  task automatic test_sub_chain();
    int seq1[5] = '{12, 5, 11, 8, 7};
    int seq2[3] = '{3, 1, 7};
    foreach (seq1[i]) press0(seq1[i], 2, $sformatf("sub[%0d]", i));
    expect_final("sub", 1022, 2, 1);
    foreach (seq2[i]) press0(seq2[i], 1, $sformatf("chain[%0d]", i));
    expect_final("chain", 0, 2, 1);
    press0(7, 1, "eq_in_equal");
  endtask

  task automatic test_max_digits();
    int seq1[5] = '{12, 10, 10, 10, 10};
    int seq2[9] = '{12, 10, 10, 10, 3, 10, 10, 10, 7};
    foreach (seq1[i]) press0(seq1[i], 1, $sformatf("maxd[%0d]", i));
    expect_final("maxd", 999, 0, 0);
    foreach (seq2[i]) press0(seq2[i], 1, $sformatf("big[%0d]", i));
    expect_final("big", 974, 2, 1);
    press0(4, 1, "digit_after_eq");
    expect_final("digit_after_eq", 4, 0, 0);
  endtask

  task automatic test_clear_ignore();
    int seq[5] = '{12, 4, 3, 6, 12};
    foreach (seq[i]) press0(seq[i], 2, $sformatf("clr[%0d]", i));
    expect_final("clr", 0, 0, 0);
    press0(7, 1, "eq_in_first");
    press0(15, 3, "code15");
    press0(21, 2, "code21");
    expect_final("ignored", 0, 0, 0);
  endtask

  task automatic test_div3();
    int acks;
    int first;
    acks      = 0;
    key_code3 = 5'd5;
    key_flag3 = 1'b1;
    repeat (40) begin
      @(posedge clk_in); #1;
      if (key_ack3) acks++;
    end
    total++;
    if (acks != 0) begin
      bad++;
      $display("FAIL div3 ack while held got=%0d exp=0", acks);
    end
    key_flag3 = 1'b0;
    first     = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk_in); #1;
      if (key_ack3) begin
        first = i;
        break;
      end
    end
    total++;
    if (first < 1 || first > 8) begin
      bad++;
      $display("FAIL div3 ack latency got=%0d exp=1..8", first);
    end
    total++;
    if (display3 !== 10'd5) begin
      bad++;
      $display("FAIL div3 display got=%0d exp=5", display3);
    end
    // The ack edge was a tick; a one-cycle glitch right after it falls
    // between ticks and must be invisible.
    acks      = 0;
    key_code3 = 5'd1;
    key_flag3 = 1'b1;
    @(posedge clk_in); #1;
    key_flag3 = 1'b0;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (key_ack3) acks++;
    end
    total++;
    if (acks != 0) begin
      bad++;
      $display("FAIL div3 glitch ack got=%0d exp=0", acks);
    end
    total++;
    if (display3 !== 10'd5) begin
      bad++;
      $display("FAIL div3 glitch display got=%0d exp=5", display3);
    end
  endtask

  task automatic test_reset_mid();
    int seq[4] = '{12, 4, 3, 6};
    foreach (seq[i]) press0(seq[i], 1, $sformatf("mid[%0d]", i));
    expect_final("mid_pre", 6, 1, 0);
    // Key held into and through reset: one event when finally released.
    key_code0 = 5'd1;
    key_flag0 = 1'b1;
    @(posedge clk_in);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({display0, state0, op0, ovf0, key_ack0} !== '0) begin
      bad++;
      $display("FAIL mid_reset outputs got=%h exp=0", {display0, state0, op0, ovf0, key_ack0});
    end
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    press0(1, 3, "held_through_reset");
    expect_final("held_through_reset", 2, 0, 0);
  endtask

  task automatic test_random();
    int r;
    int code;
    press0(12, 1, "rnd_clear");
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16)       code = r;
      else if (r < 19)  code = (r == 16) ? 7 : ((r == 17) ? 3 : 11);
      else              code = int'($urandom_range(16, 31));
      press0(code, int'($urandom_range(1, 4)), $sformatf("rnd[%0d] code=%0d", i, code));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_chain();
    test_max_digits();
    test_clear_ignore();
    test_div3();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_core_param.md
CALC_CORE_PARAM -- requirements
Module: calc_core_param

Interface
REQ-001 Parameter WIDTH, default 10: operand/result width in bits, minimum 4.
REQ-002 Parameter MAX_DIGITS, default 3: maximum decimal digits accepted per operand.
REQ-003 Parameter DIV_LOG2, default 10: key-sample tick period is 2^DIV_LOG2 clk_in cycles; 0 means every cycle.
REQ-004 clk_in  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_flag  input  1  key held (keyboard scanner flag).
REQ-007 key_code  input  5  scanner code of held key.
REQ-008 display  output  WIDTH  value currently shown: operand being entered or result.
REQ-009 state_o  output  2  0=FIRST_NUM, 1=SECOND_NUM, 2=EQUAL.
REQ-010 op_o  output  1  pending operator: 0=add, 1=subtract.
REQ-011 ovf  output  1  last result wrapped (carry on add, borrow on subtract).
REQ-012 key_ack  output  1  one-cycle pulse when a key release is accepted.

Function
REQ-013 Free-running DIV_LOG2-bit divider; tick asserted one cycle per 2^DIV_LOG2 cycles (always, if DIV_LOG2=0).
REQ-014 key_flag sampled only on tick into prev_flag; release event = tick with key_flag=0 and prev_flag=1.
REQ-015 All actions occur on the release-event edge using key_code sampled on that same tick; key_ack pulses on that edge's next cycle; outputs registered.
REQ-016 Key map: codes 0-2 -> digits 1-3; 4-6 -> 4-6; 8-10 -> 7-9; 13 -> 0; 3 -> '+'; 11 -> '-'; 7 -> '='; 12 -> clear; all other codes ignored (no ack).
REQ-017 Digit entry: acc = acc*10 + digit, truncated to WIDTH bits; digit count per operand increments; digits beyond MAX_DIGITS ignored, still acked.
REQ-018 FIRST_NUM: digit -> entry; '+'/'-' -> latch acc to operand A, set op_o, clear acc and digit count, go SECOND_NUM; '=' ignored (no ack).
REQ-019 SECOND_NUM: digit -> entry; '=' -> result = A+acc or A-acc modulo 2^WIDTH, ovf = carry/borrow, display = result, go EQUAL; '+'/'-' -> update op_o only, stay.
REQ-020 EQUAL: '+'/'-' -> A = result (chaining), set op_o, clear acc, go SECOND_NUM; digit -> acc = digit, count=1, ovf=0, go FIRST_NUM; '=' ignored.
REQ-021 Clear (code 12) in any state: acc, A, digit count, ovf, op_o cleared, go FIRST_NUM.
REQ-022 ovf retains its value until next '=', clear, or digit in EQUAL.
REQ-023 display equals acc in FIRST_NUM/SECOND_NUM, result in EQUAL.
REQ-024 Held key across many ticks produces exactly one event, on release only.
REQ-025 Illegal state encoding 3 -> FIRST_NUM on next clock with registers cleared.

Reset
REQ-026 rst_n low immediately forces: divider 0, prev_flag 0, state FIRST_NUM, display 0, acc 0, A 0, op_o 0, ovf 0, key_ack 0.
REQ-027 Reset mid-entry or mid-keypress discards all state; a key held through reset release produces one event when released.

Verification (DIV_LOG2=0 unless stated, WIDTH=10, MAX_DIGITS=3)
REQ-028 Keys 1,2,'+',3,4,'=' -> display 46, state 2, ovf 0.
REQ-029 Keys 5,'-',7,'=' -> display 1022, ovf 1; then '+',2,'=' -> display 0, ovf 1 (chaining, wrap).
REQ-030 Keys 9,9,9,9 -> display 999 (4th digit ignored, key_ack still pulses); 9,9,9,'+',9,9,9,'=' -> 1998 mod 1024 = 974, ovf 1.
REQ-031 DIV_LOG2=3: key_flag high 40 cycles then low -> exactly one key_ack, within 8 cycles of fall; glitch high for 1 cycle between ticks -> no event.
REQ-032 Keys 4,'+',6 then clear -> display 0, state 0; code 15 pressed/released -> no key_ack, no change.
REQ-033 rst_n asserted during SECOND_NUM entry -> all outputs zero asynchronously, state 0.
